// File: rtl/uart_pkg.sv
// Shared UART definitions used by both halves of the UART pair:
// FSM state encoding, oversampling ratio and default frame geometry.
package uart_pkg;

    // Receiver and transmitter both run from a 16x baud enable.
    localparam int OVERSAMPLE     = 16;

    // Default frame geometry; uart_rx uses the same defaults.
    localparam int DATA_WIDTH_DEF = 8;
    localparam int SB_TICK_DEF    = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Transmitter-side bundle: baud enable, send request/data and the
// serial line plus status flags. The master drives requests; the
// slave is the transmitter itself.
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF
);
    logic                  s_tick;
    logic                  tx_start;
    logic [data_width-1:0] tx_din;
    logic                  tx_out;
    logic                  tx_busy;
    logic                  tx_done_tick;

    modport master (
        output s_tick,
        output tx_start,
        output tx_din,
        input  tx_out,
        input  tx_busy,
        input  tx_done_tick
    );

    modport slave (
        input  s_tick,
        input  tx_start,
        input  tx_din,
        output tx_out,
        output tx_busy,
        output tx_done_tick
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, data_width data bits LSB first, optional
// even parity bit, stop bit of SB_TICK ticks. Bit timing from the shared
// 16x s_tick enable. Define UART_TX_PARITY_EN to insert the parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF,
    parameter int SB_TICK    = SB_TICK_DEF
) (
    input  logic     clk,
    input  logic     reset_in,
    uart_tx_if.slave bus
);

    // Stop bits longer than one bit period need a 5-bit tick counter.
    localparam int             S_W    = (SB_TICK > OVERSAMPLE) ? 5 : 4;
    localparam logic [S_W-1:0] S_ONE  = S_W'(1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] SB_LAST = S_W'(SB_TICK - 1);
    localparam logic [2:0]     N_LAST = 3'(data_width - 1);

    uart_state_t           state_reg;
    logic [S_W-1:0]        s_reg;
    logic [2:0]            n_reg;
    logic [data_width-1:0] b_reg;
    logic                  tx_reg;
    logic                  busy_reg;
    logic                  done_reg;
`ifdef UART_TX_PARITY_EN
    logic                  par_reg;
`endif

    // Frame sequencer; line and status flags are registered alongside state.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (bus.tx_start) begin
                        b_reg     <= bus.tx_din;
                        s_reg     <= '0;
                        state_reg <= START;
                        tx_reg    <= 1'b0;
                        busy_reg  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        // Even parity of the word as captured.
                        par_reg   <= ^bus.tx_din;
`endif
                    end
                end
                START: begin
                    if (bus.s_tick) begin
                        if (s_reg == S_LAST) begin
                            s_reg     <= '0;
                            n_reg     <= '0;
                            state_reg <= DATA;
                            tx_reg    <= b_reg[0];
                        end else begin
                            s_reg <= s_reg + S_ONE;
                        end
                    end
                end
                DATA: begin
                    if (bus.s_tick) begin
                        if (s_reg == S_LAST) begin
                            s_reg <= '0;
                            b_reg <= b_reg >> 1;
                            if (n_reg == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                                state_reg <= PARITY;
                                tx_reg    <= par_reg;
`else
                                state_reg <= STOP;
                                tx_reg    <= 1'b1;
`endif
                            end else begin
                                n_reg  <= n_reg + 3'd1;
                                // Next bit is what lands in b[0] after the shift.
                                tx_reg <= b_reg[1];
                            end
                        end else begin
                            s_reg <= s_reg + S_ONE;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bus.s_tick) begin
                        if (s_reg == S_LAST) begin
                            s_reg     <= '0;
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            s_reg <= s_reg + S_ONE;
                        end
                    end
                end
`endif
                STOP: begin
                    if (bus.s_tick) begin
                        if (s_reg == SB_LAST) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            s_reg <= s_reg + S_ONE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_out       = tx_reg;
    assign bus.tx_busy      = busy_reg;
    assign bus.tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: two instances (SB_TICK 16 and 32). The
// stimulus pushes expected frames; a per-instance monitor decodes the
// serial line by counting s_tick pulses and compares frame by frame.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int STOP_IDX = 1 + 8 + PAR_BITS;

    typedef struct {
        logic [7:0] data;
        int         ticks;
        bit         abort;
        bit         chk_gap;
    } exp_t;

    logic clk;
    logic tick_raw;
    int   tcnt;

    logic       rst     [2];
    logic       start   [2];
    logic [7:0] din     [2];
    logic       tick_en [2];
    logic       tick_s  [2];
    logic       line_s  [2];
    logic       busy_s  [2];
    logic       done_s  [2];

    exp_t q0[$];
    exp_t q1[$];

    int tests_run = 0;
    int fails     = 0;

    task automatic check(input string name, input int act, input int req);
        tests_run++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic pop(input int g, output bit got, output exp_t e);
        got = 1'b0;
        e   = '{data: 8'h00, ticks: 0, abort: 1'b0, chk_gap: 1'b0};
        if (g == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
        if (g == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running 16x baud enable: one clk in four.
    initial begin
        tick_raw = 1'b0;
        tcnt     = 0;
        forever begin
            @(posedge clk);
            #1;
            tick_raw = (tcnt == 3);
            tcnt     = (tcnt + 1) % 4;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            uart_tx_if #(.data_width(8)) bus ();

            assign bus.s_tick   = tick_raw & tick_en[gi];
            assign bus.tx_start = start[gi];
            assign bus.tx_din   = din[gi];
            assign tick_s[gi]   = bus.s_tick;
            assign line_s[gi]   = bus.tx_out;
            assign busy_s[gi]   = bus.tx_busy;
            assign done_s[gi]   = bus.tx_done_tick;

            uart_tx #(.data_width(8), .SB_TICK(gi == 0 ? 16 : 32)) u_dut (
                .clk      (clk),
                .reset_in (rst[gi]),
                .bus      (bus)
            );

            // Frame decoder and scoreboard comparison.
            initial begin : mon
                exp_t       e;
                bit         got;
                int         c, k, tk, cyc, since_done, gap, bad_stop, bad_busy;
                logic [7:0] d;
                logic       start_ok, par_bit, aborted, timeout;
                since_done = 1000;
                forever begin
                    do begin
                        @(negedge clk);
                        since_done++;
                        if (rst[gi] == 1'b0 && done_s[gi] == 1'b1) begin
                            tests_run++;
                            fails++;
                            $display("FAIL dut%0d_spurious_done: got 1 required 0", gi);
                        end
                    end while (!(rst[gi] == 1'b0 && line_s[gi] == 1'b0));
                    gap = since_done;
                    c = 0; d = '0; start_ok = 1'b0; par_bit = 1'b0;
                    bad_stop = 0; bad_busy = 0; aborted = 1'b0; timeout = 1'b0; cyc = 0;
                    forever begin
                        if (rst[gi]) begin aborted = 1'b1; break; end
                        if (done_s[gi]) break;
                        if (cyc > 4000) begin timeout = 1'b1; break; end
                        tk = tick_s[gi] ? 1 : 0;
                        c  = c + tk;
                        // Bit index visible on the line this cycle.
                        k  = (c - tk) / 16;
                        if (tk == 1 && (c % 16) == 8) begin
                            if (k == 0)
                                start_ok = (line_s[gi] == 1'b0);
                            else if (k <= 8)
                                d[k-1] = line_s[gi];
                            else if (PAR_BITS == 1 && k == 9)
                                par_bit = line_s[gi];
                        end
                        if (k >= STOP_IDX && line_s[gi] != 1'b1) bad_stop++;
                        if (busy_s[gi] != 1'b1) bad_busy++;
                        cyc++;
                        @(negedge clk);
                    end
                    pop(gi, got, e);
                    if (!got) begin
                        tests_run++;
                        fails++;
                        $display("FAIL dut%0d_unexpected_frame: got data %02h required no frame", gi, d);
                    end else if (e.abort) begin
                        $display("[TB] dut%0d frame %02h aborted by reset", gi, e.data);
                        check($sformatf("dut%0d_abort", gi), int'(aborted), 1);
                    end else begin
                        $display("[TB] dut%0d frame data=%02h ticks=%0d gap=%0d", gi, d, c, gap);
                        check($sformatf("dut%0d_timeout", gi), int'(timeout), 0);
                        check($sformatf("dut%0d_aborted", gi), int'(aborted), 0);
                        check($sformatf("dut%0d_start_bit", gi), int'(start_ok), 1);
                        check($sformatf("dut%0d_data", gi), int'(d), int'(e.data));
                        check($sformatf("dut%0d_frame_ticks", gi), c, e.ticks);
                        check($sformatf("dut%0d_stop_high", gi), bad_stop, 0);
                        check($sformatf("dut%0d_busy_in_frame", gi), bad_busy, 0);
                        check($sformatf("dut%0d_busy_at_done", gi), int'(busy_s[gi]), 0);
                        check($sformatf("dut%0d_line_at_done", gi), int'(line_s[gi]), 1);
                        if (PAR_BITS == 1)
                            check($sformatf("dut%0d_parity", gi), int'(par_bit), int'(^e.data));
                        if (e.chk_gap)
                            check($sformatf("dut%0d_gap", gi), gap, 1);
                    end
                    since_done = (done_s[gi] && !aborted) ? 0 : 1000;
                end
            end
        end
    endgenerate

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_frame(input int g, input logic [7:0] d, input bit ab, input bit gp);
        exp_t e;
        e.data    = d;
        e.ticks   = 16 * (1 + 8 + PAR_BITS) + (g == 0 ? 16 : 32);
        e.abort   = ab;
        e.chk_gap = gp;
        if (g == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic send(input int g, input logic [7:0] d, input bit ab);
        expect_frame(g, d, ab, 1'b0);
        din[g]   = d;
        start[g] = 1'b1;
        step();
        start[g] = 1'b0;
        din[g]   = ~d;
        check($sformatf("dut%0d_accept_busy", g), int'(busy_s[g]), 1);
        check($sformatf("dut%0d_accept_line", g), int'(line_s[g]), 0);
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while (busy_s[g] && n < 5000) begin step(); n++; end
        if (busy_s[g]) begin
            tests_run++;
            fails++;
            $display("FAIL dut%0d_wait_idle: got busy 1 required 0 within 5000 clk", g);
        end
        step();
    endtask

    task automatic wait_ticks(input int g, input int n);
        int k;
        k = 0;
        while (k < n) begin
            step();
            if (tick_s[g]) k++;
        end
    endtask

    initial begin
        int   n;
        int   changed;
        logic ref_line;
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; start[g] = 1'b0; din[g] = 8'h00; tick_en[g] = 1'b1;
        end
        repeat (3) step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        step();
        for (int g = 0; g < 2; g++) begin
            check($sformatf("dut%0d_reset_line", g), int'(line_s[g]), 1);
            check($sformatf("dut%0d_reset_busy", g), int'(busy_s[g]), 0);
            check($sformatf("dut%0d_reset_done", g), int'(done_s[g]), 0);
        end

        // Basic frame.
        send(0, 8'hA5, 1'b0);
        wait_idle(0);

        // Request during DATA is ignored; new tx_din does not leak in.
        send(0, 8'h3C, 1'b0);
        wait_ticks(0, 40);
        din[0]   = 8'hFF;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        wait_idle(0);

        // tx_start held high: back-to-back frames.
        expect_frame(0, 8'h01, 1'b0, 1'b0);
        expect_frame(0, 8'h80, 1'b0, 1'b1);
        din[0]   = 8'h01;
        start[0] = 1'b1;
        step();
        din[0] = 8'h80;
        n = 0;
        while (busy_s[0] && n < 5000) begin step(); n++; end
        step();
        start[0] = 1'b0;
        check("dut0_b2b_accept", int'(busy_s[0]), 1);
        wait_idle(0);

        // Reset in data bit 3 aborts the frame.
        send(0, 8'h55, 1'b1);
        wait_ticks(0, 72);
        rst[0] = 1'b1;
        #1;
        check("dut0_rst_line", int'(line_s[0]), 1);
        check("dut0_rst_busy", int'(busy_s[0]), 0);
        check("dut0_rst_done", int'(done_s[0]), 0);
        step();
        rst[0] = 1'b0;
        step();
        send(0, 8'hAA, 1'b0);
        wait_idle(0);

        // Parity-sensitive words (parity 1, then 0 when enabled).
        send(0, 8'h07, 1'b0);
        wait_idle(0);
        send(0, 8'h03, 1'b0);
        wait_idle(0);

        // Long stop bit and tick gating on the second instance.
        send(1, 8'h00, 1'b0);
        wait_ticks(1, 40);
        tick_en[1] = 1'b0;
        ref_line   = line_s[1];
        changed    = 0;
        repeat (100) begin
            step();
            if (line_s[1] != ref_line || busy_s[1] != 1'b1) changed++;
        end
        check("dut1_gate_freeze", changed, 0);
        tick_en[1] = 1'b1;
        wait_idle(1);

        repeat (20) step();
        check("dut0_queue_empty", q0.size(), 0);
        check("dut1_queue_empty", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
